// File: rtl/win_pkg.sv
// Shared types and defaults for the 3x3 window scan path: FSM states,
// RAM-rotation helper and default frame geometry.
package win_pkg;

  localparam int WIN_DATA_WIDTH = 8;
  localparam int WIN_WIDTH      = 10;
  localparam int WIN_HEIGHT     = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROW    = 2'd1,
    S_HBLANK = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Three line-buffer RAMs rotate 0 -> 1 -> 2 -> 0
  function automatic logic [1:0] rot_next(input logic [1:0] rot);
    return (rot == 2'd2) ? 2'd0 : rot + 2'd1;
  endfunction

endpackage

// File: rtl/win_tag_pipe.sv
// Delay line for window-centre tags {valid,x,y}, LAT cycles deep.
// Latency: LAT cycles. No backpressure; synchronous flush clears every stage.
module win_tag_pipe #(
  parameter int LAT = 2,
  parameter int XW  = 4,
  parameter int YW  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  output logic          out_vld,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y
);

  logic [LAT-1:0] vld_q;
  logic [XW-1:0]  x_q [LAT];
  logic [YW-1:0]  y_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      x_q[0]   <= in_x;
      y_q[0]   <= in_y;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        x_q[i]   <= x_q[i-1];
        y_q[i]   <= y_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[LAT-1];
  assign out_x   = x_q[LAT-1];
  assign out_y   = y_q[LAT-1];

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-scan controller: x/y counters, line-buffer writes, row rotation, centre tags.
// Latency: writes 1 cycle after accept; ctr_valid 1+WIN_LAT cycles after accept.
// Backpressure: s_ready low outside ROW (idle, horizontal blank, done) and during abort.
module window_scan_ctrl
  import win_pkg::*;
#(
  parameter int  DATA_WIDTH = WIN_DATA_WIDTH,
  parameter int  WIDTH      = WIN_WIDTH,
  parameter int  HEIGHT     = WIN_HEIGHT,
  parameter int  HBLANK     = 2,
  parameter int  WIN_LAT    = 2,
  localparam int XW         = $clog2(WIDTH),
  localparam int YW         = $clog2(HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  lb_wr_en,
  output logic [XW-1:0]         lb_addr,
  output logic [DATA_WIDTH-1:0] lb_wr_data,
  output logic [1:0]            lb_rot,
  output logic                  win_in_valid,
  output logic                  ctr_valid,
  output logic [XW-1:0]         ctr_x,
  output logic [YW-1:0]         ctr_y,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int HW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [HW-1:0] HB_LAST = HW'((HBLANK > 0) ? HBLANK - 1 : 0);

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    rot_q, rot_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          accept;
  logic          tag_vld;
  logic [XW-1:0] tag_x;
  logic [YW-1:0] tag_y;

  // Abort gates the handshake so upstream never loses a pixel to a flushed frame
  assign accept = (state_q == S_ROW) && s_valid && !abort;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rot_d   = rot_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ROW;
          x_d     = '0;
          y_d     = '0;
          rot_d   = '0;
        end
      end
      S_ROW: begin
        if (accept) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              state_d = S_DONE;
            end else begin
              y_d     = y_q + 1'b1;
              rot_d   = rot_next(rot_q);
              hcnt_d  = '0;
              state_d = (HBLANK > 0) ? S_HBLANK : S_ROW;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (hcnt_q == HB_LAST) state_d = S_ROW;
        else                   hcnt_d  = hcnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      x_d     = '0;
      y_d     = '0;
      rot_d   = '0;
      hcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      rot_q      <= '0;
      hcnt_q     <= '0;
      lb_wr_en   <= 1'b0;
      lb_addr    <= '0;
      lb_wr_data <= '0;
      lb_rot     <= '0;
      tag_vld    <= 1'b0;
      tag_x      <= '0;
      tag_y      <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rot_q    <= rot_d;
      hcnt_q   <= hcnt_d;
      lb_wr_en <= accept;
      if (abort) begin
        lb_addr <= '0;
        lb_rot  <= '0;
      end else if (accept) begin
        lb_addr    <= x_q;
        lb_wr_data <= s_data;
        lb_rot     <= rot_q;
      end
      // Pixel (x,y) closes the unpadded window centred one row/column back
      tag_vld <= accept && (x_q >= XW'(2)) && (y_q >= YW'(2));
      tag_x   <= x_q - 1'b1;
      tag_y   <= y_q - 1'b1;
    end
  end

  assign s_ready      = (state_q == S_ROW) && !abort;
  assign win_in_valid = lb_wr_en;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_DONE);

  win_tag_pipe #(
    .LAT (WIN_LAT),
    .XW  (XW),
    .YW  (YW)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .in_vld  (tag_vld),
    .in_x    (tag_x),
    .in_y    (tag_y),
    .out_vld (ctr_valid),
    .out_x   (ctr_x),
    .out_y   (ctr_y)
  );

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl at 10x8 frame, HBLANK=2, WIN_LAT=2.
module tb_window_scan_ctrl;

  localparam int W  = 10;
  localparam int H  = 8;
  localparam int HB = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, s_valid, s_ready;
  logic [7:0] s_data, lb_wr_data;
  logic       lb_wr_en, win_in_valid, ctr_valid, busy, frame_done;
  logic [3:0] lb_addr, ctr_x;
  logic [2:0] ctr_y;
  logic [1:0] lb_rot;

  window_scan_ctrl #(
    .DATA_WIDTH (8), .WIDTH (W), .HEIGHT (H), .HBLANK (HB), .WIN_LAT (2)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
    .lb_wr_en (lb_wr_en), .lb_addr (lb_addr), .lb_wr_data (lb_wr_data),
    .lb_rot (lb_rot), .win_in_valid (win_in_valid), .ctr_valid (ctr_valid),
    .ctr_x (ctr_x), .ctr_y (ctr_y), .busy (busy), .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Frame statistics gathered by run_frame
  int wr_cnt, wr_mis, addr_err, rot_err, data_err, vld_err;
  int ctr_cnt, first_x, first_y, first_cyc, last_x, last_y, acc22_cyc, seq_err;
  int fd_cnt, fd_wr, busy_post_err, gap_cnt, gap_err, timed_out;

  task automatic run_frame(input bit toggle, input bit poke);
    int  pix, run, post;
    bit  prev_acc, acc, seen_ready, fd_seen;
    wr_cnt = 0; wr_mis = 0; addr_err = 0; rot_err = 0; data_err = 0; vld_err = 0;
    ctr_cnt = 0; first_x = -1; first_y = -1; first_cyc = -100; last_x = -1; last_y = -1;
    acc22_cyc = 0; seq_err = 0; fd_cnt = 0; fd_wr = -1; busy_post_err = 0;
    gap_cnt = 0; gap_err = 0; timed_out = 1;
    pix = 0; run = 0; post = 0; prev_acc = 0; seen_ready = 0; fd_seen = 0;
    @(negedge clk);
    start = 1'b1; s_valid = 1'b1; s_data = 8'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (lb_wr_en !== prev_acc) wr_mis++;
      if (win_in_valid !== lb_wr_en) vld_err++;
      if (lb_wr_en === 1'b1) begin
        if (int'(lb_addr) != wr_cnt % W) addr_err++;
        if (int'(lb_rot) != (wr_cnt / W) % 3) rot_err++;
        if (int'(lb_wr_data) != wr_cnt % 256) data_err++;
        wr_cnt++;
      end
      if (ctr_valid === 1'b1) begin
        if (ctr_cnt == 0) begin
          first_x = int'(ctr_x); first_y = int'(ctr_y); first_cyc = cyc;
        end
        last_x = int'(ctr_x); last_y = int'(ctr_y);
        if (int'(ctr_x) != 1 + ctr_cnt % (W - 2) || int'(ctr_y) != 1 + ctr_cnt / (W - 2))
          seq_err++;
        ctr_cnt++;
      end
      if (fd_seen) begin
        post++;
        if (busy !== 1'b0) busy_post_err++;
        if (frame_done === 1'b1) fd_cnt++;
      end else if (frame_done === 1'b1) begin
        fd_cnt++; fd_wr = wr_cnt; fd_seen = 1;
      end
      if (s_ready === 1'b1) begin
        if (run > 0) begin
          gap_cnt++;
          if (run != HB) gap_err++;
          run = 0;
        end
        seen_ready = 1;
      end else if (seen_ready && busy === 1'b1 && frame_done !== 1'b1) begin
        run++;
      end
      start   = poke && (cyc == 40 || frame_done === 1'b1);
      s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data  = 8'(pix);
      #1;
      acc = s_valid && s_ready;
      if (acc) begin
        if (pix == 22) acc22_cyc = cyc;
        pix++;
      end
      prev_acc = acc;
      if (post >= 5) begin
        timed_out = 0;
        break;
      end
    end
    start = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
    #12;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (lb_wr_en !== 1'b0 || lb_addr !== 4'd0 || lb_rot !== 2'd0 || lb_wr_data !== 8'd0)
      begin failures++; $display("FAIL reset_lb got=%b/%0d/%0d/%0d want=0", lb_wr_en, lb_addr, lb_rot, lb_wr_data); end
    checks++; if (ctr_valid !== 1'b0 || ctr_x !== 4'd0 || ctr_y !== 3'd0 || frame_done !== 1'b0)
      begin failures++; $display("FAIL reset_ctr got=%b/%0d/%0d fd=%b want=0", ctr_valid, ctr_x, ctr_y, frame_done); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0 || lb_wr_en !== 1'b0 || ctr_valid !== 1'b0 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet cyc=%0d got rdy=%b busy=%b wr=%b cv=%b fd=%b want all 0",
                 i, s_ready, busy, lb_wr_en, ctr_valid, frame_done);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_frame;
    run_frame(1'b0, 1'b0);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL frame_timeout got=%0d want=0", timed_out); end
    checks++; if (wr_cnt != 80) begin failures++; $display("FAIL frame_writes got=%0d want=80", wr_cnt); end
    checks++; if (wr_mis != 0 || vld_err != 0) begin failures++; $display("FAIL frame_wr_timing got=%0d/%0d want=0", wr_mis, vld_err); end
    checks++; if (addr_err != 0 || data_err != 0) begin failures++; $display("FAIL frame_addr_data got=%0d/%0d want=0", addr_err, data_err); end
    checks++; if (rot_err != 0) begin failures++; $display("FAIL frame_rot got=%0d want=0", rot_err); end
    checks++; if (gap_cnt != 7 || gap_err != 0) begin failures++; $display("FAIL frame_hblank got gaps=%0d bad=%0d want 7/0", gap_cnt, gap_err); end
    checks++; if (fd_cnt != 1 || fd_wr != 80) begin failures++; $display("FAIL frame_done got cnt=%0d at_wr=%0d want 1/80", fd_cnt, fd_wr); end
    checks++; if (busy_post_err != 0) begin failures++; $display("FAIL frame_busy_drop got=%0d want=0", busy_post_err); end
  endtask

  task automatic test_ctr;
    run_frame(1'b0, 1'b0);
    checks++; if (ctr_cnt != 48) begin failures++; $display("FAIL ctr_count got=%0d want=48", ctr_cnt); end
    checks++; if (first_x != 1 || first_y != 1) begin failures++; $display("FAIL ctr_first got=(%0d,%0d) want=(1,1)", first_x, first_y); end
    checks++; if (first_cyc - acc22_cyc != 3) begin failures++; $display("FAIL ctr_latency got=%0d want=3", first_cyc - acc22_cyc); end
    checks++; if (last_x != 8 || last_y != 6) begin failures++; $display("FAIL ctr_last got=(%0d,%0d) want=(8,6)", last_x, last_y); end
    checks++; if (seq_err != 0) begin failures++; $display("FAIL ctr_sequence got=%0d want=0", seq_err); end
  endtask

  task automatic test_toggle;
    run_frame(1'b1, 1'b0);
    checks++; if (wr_cnt != 80) begin failures++; $display("FAIL tog_writes got=%0d want=80", wr_cnt); end
    checks++; if (wr_mis != 0) begin failures++; $display("FAIL tog_no_invalid_write got=%0d want=0", wr_mis); end
    checks++; if (addr_err != 0 || rot_err != 0) begin failures++; $display("FAIL tog_addr_rot got=%0d/%0d want=0", addr_err, rot_err); end
    checks++; if (ctr_cnt != 48 || seq_err != 0) begin failures++; $display("FAIL tog_ctr got cnt=%0d bad=%0d want 48/0", ctr_cnt, seq_err); end
    checks++; if (first_cyc - acc22_cyc != 3) begin failures++; $display("FAIL tog_ctr_latency got=%0d want=3", first_cyc - acc22_cyc); end
  endtask

  task automatic test_abort;
    int pix;
    bit hit;
    pix = 0; hit = 0;
    @(negedge clk); start = 1'b1; s_valid = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (pix == 35) begin hit = 1; break; end
      #1;
      if (s_ready === 1'b1) pix++;
    end
    checks++; if (!hit) begin failures++; $display("FAIL abort_reach got=%0d want=35", pix); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b rdy=%b want 0/0", busy, s_ready); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ctr_valid !== 1'b0 || frame_done !== 1'b0 || lb_wr_en !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet cyc=%0d got cv=%b fd=%b wr=%b want 0", i, ctr_valid, frame_done, lb_wr_en);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    run_frame(1'b0, 1'b0);
    checks++; if (wr_cnt != 80 || addr_err != 0 || rot_err != 0) begin failures++; $display("FAIL abort_restart got wr=%0d aerr=%0d rerr=%0d want 80/0/0", wr_cnt, addr_err, rot_err); end
    checks++; if (ctr_cnt != 48 || seq_err != 0) begin failures++; $display("FAIL abort_restart_ctr got=%0d/%0d want 48/0", ctr_cnt, seq_err); end
  endtask

  task automatic test_start_ignored;
    run_frame(1'b0, 1'b1);
    checks++; if (wr_cnt != 80 || addr_err != 0 || rot_err != 0) begin failures++; $display("FAIL poke_counters got wr=%0d aerr=%0d rerr=%0d want 80/0/0", wr_cnt, addr_err, rot_err); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL poke_one_done got=%0d want=1", fd_cnt); end
    checks++; if (busy_post_err != 0) begin failures++; $display("FAIL poke_stays_idle got=%0d want=0", busy_post_err); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); start = 1'b1; s_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || lb_wr_en !== 1'b0 || lb_addr !== 4'd0)
      begin failures++; $display("FAIL midreset got busy=%b rdy=%b wr=%b addr=%0d want 0", busy, s_ready, lb_wr_en, lb_addr); end
    @(negedge clk); rst_n = 1'b1; s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ctr();
    test_toggle();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
